// File: rtl/pc_seq_pkg.sv
// ----------------------------------------------------------------------------
// pc_seq_pkg
// Shared definitions for the program-counter sequencer:
//   - pc_state_e   : sequencer FSM states (IDLE / RUN / STALL / HALT)
//   - PC_W_DEF     : default PC width in bits
//   - RESET_PC_DEF : default PC value used on reset and on clear
// ----------------------------------------------------------------------------
package pc_seq_pkg;

    localparam int PC_W_DEF     = 2;
    localparam int RESET_PC_DEF = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } pc_state_e;

endpackage : pc_seq_pkg

// File: rtl/pc_incr.sv
// ----------------------------------------------------------------------------
// pc_incr
// PC_W-bit +1 incrementer with carry-out. Carry is set exactly when the
// input is all-ones, i.e. when the sum wraps to zero.
// Ports:
//   i_a      in   PC_W  operand
//   o_sum    out  PC_W  i_a + 1 modulo 2^PC_W
//   o_carry  out  1     carry-out of the addition
// ----------------------------------------------------------------------------
module pc_incr
    import pc_seq_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic [PC_W-1:0] i_a,
    output logic [PC_W-1:0] o_sum,
    output logic            o_carry
);

    assign {o_carry, o_sum} = {1'b0, i_a} + {{PC_W{1'b0}}, 1'b1};

endmodule : pc_incr

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
// Program-counter register stage. Drives the +1 incrementer from the current
// PC and registers its sum as the next PC when fetch accepts the current one.
// Supports jump loads, stalls, a synchronous clear, and either halting or
// wrapping when the increment carries out (WRAP_HALT).
//
// Optional feature macro: PC_SKIP_EN
//   defined   -> adds input `skip`; an accept with skip=1 advances by 2
//                through a second chained incrementer; carry is the OR of
//                both stage carries.
//   undefined -> no skip port; the advance is always +1.
//
// Ports:
//   clk          in   1     rising-edge clock
//   rst_n        in   1     asynchronous active-low reset
//   run          in   1     1 = may advance, 0 = stall (hold PC)
//   clear        in   1     synchronous return to RESET_PC / IDLE, clears flags
//   load_valid   in   1     jump request (RUN/STALL only)
//   load_addr    in   PC_W  jump target
//   fetch_ready  in   1     fetch accepts pc_out this cycle
//   skip         in   1     (PC_SKIP_EN only) advance by 2 on accept
//   pc_out       out  PC_W  current PC
//   pc_valid     out  1     pc_out is valid for fetch
//   wrap_flag    out  1     sticky: an increment produced carry-out
//   halted       out  1     FSM is in HALT
//   dbg_state    out  2     current FSM state (observation only)
//
// Handshake: a transfer (accept) happens on a rising edge where
// pc_valid=1 and fetch_ready=1. Once pc_valid is raised it stays high until
// a transfer or a control event (stall, halt, clear, reset) takes the
// sequencer out of RUN; pc_out never changes under a pending transfer
// except through an explicit jump load.
// ----------------------------------------------------------------------------
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC  = PC_W'(RESET_PC_DEF),
    parameter bit              WRAP_HALT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            clear,
    input  logic            load_valid,
    input  logic [PC_W-1:0] load_addr,
    input  logic            fetch_ready,
`ifdef PC_SKIP_EN
    input  logic            skip,
`endif
    output logic [PC_W-1:0] pc_out,
    output logic            pc_valid,
    output logic            wrap_flag,
    output logic            halted,
    output pc_state_e       dbg_state
);

    pc_state_e       r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_valid;
    logic            r_wrap;
    logic            r_halted;

    pc_state_e       w_next_state;
    logic [PC_W-1:0] w_next_pc;
    logic            w_next_wrap;
    logic            w_accept;
    logic [PC_W-1:0] w_sum1;
    logic            w_carry1;
    logic [PC_W-1:0] w_adv_sum;
    logic            w_adv_carry;

    // ---------------------------------------------------------------- datapath
    pc_incr #(.PC_W(PC_W)) u_incr1 (
        .i_a     (r_pc),
        .o_sum   (w_sum1),
        .o_carry (w_carry1)
    );

`ifdef PC_SKIP_EN
    logic [PC_W-1:0] w_sum2;
    logic            w_carry2;

    pc_incr #(.PC_W(PC_W)) u_incr2 (
        .i_a     (w_sum1),
        .o_sum   (w_sum2),
        .o_carry (w_carry2)
    );

    // A wrap in either stage counts as a carry for the skip advance.
    assign w_adv_sum   = skip ? w_sum2 : w_sum1;
    assign w_adv_carry = w_carry1 | (skip & w_carry2);
`else
    assign w_adv_sum   = w_sum1;
    assign w_adv_carry = w_carry1;
`endif

    assign w_accept = r_valid & fetch_ready;

    // ------------------------------------------------------ next-state logic
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_next_wrap  = r_wrap;

        unique case (r_state)
            ST_IDLE: begin
                if (run) begin
                    w_next_state = ST_RUN;
                end
            end

            ST_RUN: begin
                // A jump overrides the increment and never counts as a carry.
                if (load_valid) begin
                    w_next_pc = load_addr;
                end else if (w_accept) begin
                    if (w_adv_carry && WRAP_HALT) begin
                        w_next_state = ST_HALT;
                    end else begin
                        w_next_pc = w_adv_sum;
                        if (w_adv_carry) begin
                            w_next_wrap = 1'b1;
                        end
                    end
                end
                // Halting on carry takes precedence over dropping into stall.
                if (!run && (w_next_state != ST_HALT)) begin
                    w_next_state = ST_STALL;
                end
            end

            ST_STALL: begin
                if (load_valid) begin
                    w_next_pc = load_addr;
                end
                if (run) begin
                    w_next_state = ST_RUN;
                end
            end

            ST_HALT: begin
                // Only clear or reset leave HALT; loads are ignored.
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        if (clear) begin
            w_next_state = ST_IDLE;
            w_next_pc    = RESET_PC;
            w_next_wrap  = 1'b0;
        end
    end

    // -------------------------------------------------------------- registers
    // Status outputs are registered from the next state so they line up with
    // the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_pc     <= RESET_PC;
            r_valid  <= 1'b0;
            r_wrap   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_pc     <= w_next_pc;
            r_valid  <= (w_next_state == ST_RUN);
            r_wrap   <= w_next_wrap;
            r_halted <= (w_next_state == ST_HALT);
        end
    end

    assign pc_out    = r_pc;
    assign pc_valid  = r_valid;
    assign wrap_flag = r_wrap;
    assign halted    = r_halted;
    assign dbg_state = r_state;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_sequencer
// Two sequencers share one input stream: dut_h halts on carry (WRAP_HALT=1),
// dut_w wraps and sets wrap_flag (WRAP_HALT=0). A behavioural model tracks
// both from the written rules; a compare process checks every cycle, and a
// directed opening pins the model with hand-computed literals.
// ----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam int PC_W   = 2;
    localparam int PC_MOD = 1 << PC_W;
    localparam int RST_PC = 0;

    // model modes
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_STALL = 2;
    localparam int M_HALT  = 3;

    // ------------------------------------------------------ clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            run = 1'b0;
    logic            clear = 1'b0;
    logic            load_valid = 1'b0;
    logic [PC_W-1:0] load_addr = '0;
    logic            fetch_ready = 1'b0;
`ifdef PC_SKIP_EN
    logic            skip = 1'b0;
`endif

    logic [PC_W-1:0] pc_h, pc_w;
    logic            valid_h, valid_w, wrap_h, wrap_w, halt_h, halt_w;
    logic [1:0]      st_h, st_w;

    pc_sequencer #(.PC_W(PC_W), .RESET_PC(2'd0), .WRAP_HALT(1'b1)) dut_h (
        .clk(clk), .rst_n(rst_n), .run(run), .clear(clear),
        .load_valid(load_valid), .load_addr(load_addr), .fetch_ready(fetch_ready),
`ifdef PC_SKIP_EN
        .skip(skip),
`endif
        .pc_out(pc_h), .pc_valid(valid_h), .wrap_flag(wrap_h), .halted(halt_h),
        .dbg_state(st_h)
    );

    pc_sequencer #(.PC_W(PC_W), .RESET_PC(2'd0), .WRAP_HALT(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_n), .run(run), .clear(clear),
        .load_valid(load_valid), .load_addr(load_addr), .fetch_ready(fetch_ready),
`ifdef PC_SKIP_EN
        .skip(skip),
`endif
        .pc_out(pc_w), .pc_valid(valid_w), .wrap_flag(wrap_w), .halted(halt_w),
        .dbg_state(st_w)
    );

    // ------------------------------------------------------------ scoring
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------ behavioural model
    // index 0 = halting variant, 1 = wrapping variant
    int m_pc[2];
    int m_mode[2];
    bit m_wrap[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k]   = RST_PC;
            m_mode[k] = M_IDLE;
            m_wrap[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        int step;
        step = 1;
`ifdef PC_SKIP_EN
        if (skip) step = 2;
`endif
        for (int k = 0; k < 2; k++) begin
            int nxt;
            if (clear) begin
                m_pc[k]   = RST_PC;
                m_mode[k] = M_IDLE;
                m_wrap[k] = 1'b0;
            end else begin
                case (m_mode[k])
                    M_IDLE: if (run) m_mode[k] = M_RUN;
                    M_RUN: begin
                        if (load_valid) begin
                            m_pc[k] = int'(load_addr);
                        end else if (fetch_ready) begin
                            nxt = m_pc[k] + step;
                            if (nxt >= PC_MOD && k == 0) begin
                                m_mode[k] = M_HALT;
                            end else begin
                                if (nxt >= PC_MOD) m_wrap[k] = 1'b1;
                                m_pc[k] = nxt % PC_MOD;
                            end
                        end
                        if (!run && m_mode[k] != M_HALT) m_mode[k] = M_STALL;
                    end
                    M_STALL: begin
                        if (load_valid) m_pc[k] = int'(load_addr);
                        if (run) m_mode[k] = M_RUN;
                    end
                    default: ;
                endcase
            end
        end
    endtask

    // One compare process: model advances on each edge, outputs checked 1ns later.
    always begin
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        check("h.pc_out",    32'(pc_h),    32'(m_pc[0]));
        check("h.pc_valid",  32'(valid_h), 32'(m_mode[0] == M_RUN));
        check("h.wrap_flag", 32'(wrap_h),  32'(m_wrap[0]));
        check("h.halted",    32'(halt_h),  32'(m_mode[0] == M_HALT));
        check("w.pc_out",    32'(pc_w),    32'(m_pc[1]));
        check("w.pc_valid",  32'(valid_w), 32'(m_mode[1] == M_RUN));
        check("w.wrap_flag", 32'(wrap_w),  32'(m_wrap[1]));
        check("w.halted",    32'(halt_w),  32'(m_mode[1] == M_HALT));
    end

    // ------------------------------------------------------------ drivers
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input bit r, input bit c, input bit lv, input int la, input bit fr);
        run         = r;
        clear       = c;
        load_valid  = lv;
        load_addr   = PC_W'(la);
        fetch_ready = fr;
    endtask

    // k: 0 = dut_h, 1 = dut_w
    task automatic lit(input string name, input int k, input int pc, input bit v,
                       input bit w, input bit h);
        if (k == 0) begin
            check({name, ".h.pc"},    32'(pc_h),    32'(pc));
            check({name, ".h.valid"}, 32'(valid_h), 32'(v));
            check({name, ".h.wrap"},  32'(wrap_h),  32'(w));
            check({name, ".h.halt"},  32'(halt_h),  32'(h));
        end else begin
            check({name, ".w.pc"},    32'(pc_w),    32'(pc));
            check({name, ".w.valid"}, 32'(valid_w), 32'(v));
            check({name, ".w.wrap"},  32'(wrap_w),  32'(w));
            check({name, ".w.halt"},  32'(halt_w),  32'(h));
        end
    endtask

    task automatic lit2(input string name, input int pc, input bit v);
        lit(name, 0, pc, v, 1'b0, 1'b0);
        lit(name, 1, pc, v, 1'b0, 1'b0);
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (3) cyc();
        lit2("reset", 0, 0);
        rst_n = 1'b1;

        // Count up from 0; carry on the accept at 3.
        set_in(1, 0, 0, 0, 1);
        cyc(); lit2("run.pc0", 0, 1);
        cyc(); lit2("run.pc1", 1, 1);
        cyc(); lit2("run.pc2", 2, 1);
        cyc(); lit2("run.pc3", 3, 1);
        cyc();
        lit("carry", 0, 3, 0, 0, 1);
        lit("carry", 1, 0, 1, 1, 0);
        cyc();
        lit("after_carry", 0, 3, 0, 0, 1);
        lit("after_carry", 1, 1, 1, 1, 0);

        // Clear leaves HALT and drops the sticky wrap flag.
        set_in(0, 1, 0, 0, 0); cyc(); lit2("clear1", 0, 0);

        // Back-pressure hold at pc=1.
        set_in(1, 0, 0, 0, 0); cyc(); lit2("bp.start", 0, 1);
        set_in(1, 0, 0, 0, 1); cyc(); lit2("bp.pc1", 1, 1);
        set_in(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); lit2("bp.hold", 1, 1);
        end
        set_in(1, 0, 0, 0, 1); cyc(); lit2("bp.release", 2, 1);

        // Loads: regardless of fetch_ready, and winning over an accept.
        set_in(1, 0, 1, 1, 0); cyc(); lit2("load.noacc", 1, 1);
        set_in(1, 0, 1, 3, 1); cyc(); lit2("load.wins", 3, 1);

        // Load plus run=0 from RUN, then hold and load inside STALL.
        set_in(0, 0, 1, 2, 0); cyc(); lit2("stall.load", 2, 0);
        set_in(0, 0, 0, 0, 1); cyc(); lit2("stall.hold", 2, 0);
        set_in(0, 0, 1, 0, 0); cyc(); lit2("stall.load0", 0, 0);
        set_in(1, 0, 0, 0, 0); cyc(); lit2("stall.resume", 0, 1);

        // Clear from RUN, restart, then asynchronous reset mid-run at pc=2.
        set_in(1, 1, 0, 0, 0); cyc(); lit2("clear2", 0, 0);
        set_in(1, 0, 0, 0, 1); cyc(); lit2("restart", 0, 1);
        cyc(); cyc(); lit2("pre_rst", 2, 1);
        #1 rst_n = 1'b0;
        #1 lit2("async_rst", 0, 0);
        cyc();
        set_in(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        cyc();

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            run         = ($urandom_range(0, 99) < 85);
            clear       = ($urandom_range(0, 99) < 3);
            load_valid  = ($urandom_range(0, 99) < 12);
            load_addr   = PC_W'($urandom_range(0, PC_MOD - 1));
            fetch_ready = ($urandom_range(0, 99) < 60);
`ifdef PC_SKIP_EN
            skip        = ($urandom_range(0, 99) < 30);
`endif
            if ($urandom_range(0, 199) == 0) begin
                #1 rst_n = 1'b0;
                #1 lit2("rand_async_rst", 0, 0);
            end else begin
                rst_n = 1'b1;
            end
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pc_sequencer
